keypad_scanner: RTL
===================

# keypad_scanner

Scans a 4x4 active-low matrix keypad, debounces each press, encodes it to a hex nibble and shifts it into a 32-bit entry register. It is the input-side counterpart of the eight-digit seven-segment display path. Its `value` output drives that display's 32-bit `seg` input directly, so the last eight keys typed appear on the digits, with the newest key on the rightmost digit (`seg[3:0]`).

## Interface
- `SCAN_DIV`, default 100000 — clocks each column is driven, 1 ms at 100 MHz; must be ≥ 4.
- `DEBOUNCE_CNT`, default 2000000 — consecutive stable clocks required for press and for release, 20 ms; must be ≥ 2.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `row`  in  4  keypad row lines, active-low (board pull-ups); asynchronous to `clk`.
- `col`  out  4  keypad column drive, active-low, exactly one bit low at all times.
- `value`  out  32  entry register; newest nibble in `[3:0]`.
- `key_code`  out  4  hex code of the last accepted key.
- `key_valid`  out  1  one-clock pulse when a key is accepted.

## Operation
- `row` passes through a 2-flop synchronizer (`row_s`). All decisions use `row_s`.
- The column sequence `col` is 1110 → 1101 → 1011 → 0111 → 1110. Column index c = 0..3.
- Scan counter: counts 0..SCAN_DIV-1 and produces `tick` at SCAN_DIV-1. It runs only in SCAN.
- Key map, by row r / column c:
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: 0 F E D
- FSM states: SCAN, DEBOUNCE, HELD, RELEASE.
  - SCAN, on `tick` with `row_s` ≠ 1111: latch c, latch `row_s` as `pat`, clear the debounce counter, go to DEBOUNCE; `col` frozen.
  - SCAN, on `tick` with `row_s` = 1111: advance the column.
  - DEBOUNCE: counter increments each clock while `row_s` == `pat`. Any mismatch: go to SCAN, resume at the next column, scan counter 0. When the counter reaches DEBOUNCE_CNT-1 with a match: accept, go to HELD.
  - Accept (registered, same clock edge): `key_code` ← map(r, c), where r is the lowest-index low bit of `pat` (multi-key priority); `value` ← {`value[27:0]`, `key_code`}; `key_valid` = 1 for that one clock.
  - HELD: `col` frozen. When `row_s` == 1111: clear counter, go to RELEASE.
  - RELEASE: counter increments while `row_s` == 1111. Any low bit: return to HELD, no new key. When the counter reaches DEBOUNCE_CNT-1: go to SCAN, next column, scan counter 0.
- There is no auto-repeat: one accepted key per press-release cycle.
- Chording: a second key pressed while in HELD is ignored.
- `value` wraps by shifting. The oldest nibble `[31:28]` is discarded on the 9th and later keys.

## Timing
- Reset values, applied immediately and asynchronously: `col` = 1110; `value` = 0; `key_code` = 0; `key_valid` = 0; state SCAN; all counters 0; synchronizer flops = 1111.
- Reset mid-operation (e.g. in DEBOUNCE): no `key_valid` pulse. Scanning restarts at column 0.
- Input latency: a `row` change is visible in `row_s` 2 clocks later.
- Detection: a key is detected only on `tick`, which is the last clock of a column's dwell, so lines have SCAN_DIV-1 clocks to settle.
- Press to accept: `key_valid` rises DEBOUNCE_CNT clocks after entering DEBOUNCE. `value` and `key_code` change on that same edge and hold until the next accept.
- Minimum key-to-key interval: DEBOUNCE_CNT (press) + DEBOUNCE_CNT (release) + the scan time to reach the key's column.
- `col` changes only on `tick` in SCAN or on exit from DEBOUNCE or RELEASE. It never has more than one bit low and is never 1111.

## Test plan
Use SCAN_DIV = 4 and DEBOUNCE_CNT = 8 for all cases. The keypad model pulls row r low while `col[c]` is low and key (r, c) is pressed.
- Reset, no keys: `col` cycles 1110, 1101, 1011, 0111, each held for exactly 4 clocks; `value` = 0; `key_valid` never asserted.
- Press "5" (r1, c1), held 40 clocks, then released: exactly one `key_valid` pulse; `key_code` = 5; `value` = 0x00000005; `col` = 1101 frozen until RELEASE completes.
- Keys 1, 2, …, 8, 9 in sequence: after 8 keys `value` = 0x12345678; after the 9th key `value` = 0x23456789.
- Bounce: "A" asserted for 3 clocks, released for 2, then held steady: no pulse during the bounce; one pulse with `key_code` = A once 8 stable clocks have passed.
- Simultaneous "7" and "1" (same column c0, rows r2 and r0): `key_code` = 1 (lowest row wins); releasing only "1" while "7" is held produces no new key.
- Assert `reset` mid-DEBOUNCE with "D" held: no `key_valid`; `col` = 1110 immediately. After deassertion "D" is detected and accepted once.

Source files
------------

// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner with press/release debounce.
// Accepted keys are encoded to a hex nibble and shifted into a 32-bit entry
// register whose newest nibble sits in value[3:0].
module keypad_scanner #(
  parameter int unsigned SCAN_DIV     = 100000,
  parameter int unsigned DEBOUNCE_CNT = 2000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  row,
  output logic [3:0]  col,
  output logic [31:0] value,
  output logic [3:0]  key_code,
  output logic        key_valid
);

  localparam int unsigned ScanW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned DebW  = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
  localparam logic [ScanW-1:0] ScanLast = ScanW'(SCAN_DIV - 1);
  localparam logic [DebW-1:0]  DebLast  = DebW'(DEBOUNCE_CNT - 1);

  typedef enum logic [1:0] {StScan, StDebounce, StHeld, StRelease} state_e;

  state_e           state_q;
  logic [3:0]       row_meta;
  logic [3:0]       row_s;
  logic [ScanW-1:0] scan_cnt_q;
  logic [DebW-1:0]  deb_cnt_q;
  logic [1:0]       col_idx_q;
  logic [3:0]       pat_q;
  logic [1:0]       hit_row;
  logic [3:0]       map_code;

  // Two-flop synchronizer for the asynchronous row lines (idle high).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_meta <= 4'hF;
      row_s    <= 4'hF;
    end else begin
      row_meta <= row;
      row_s    <= row_meta;
    end
  end

  // Lowest-index low row of the latched pattern wins when several keys share a column.
  always_comb begin
    hit_row = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!pat_q[i]) hit_row = 2'(i);
    end
  end

  // Key map indexed by {row, column}.
  always_comb begin
    map_code = 4'h0;
    case ({hit_row, col_idx_q})
      4'b00_00: map_code = 4'h1;
      4'b00_01: map_code = 4'h2;
      4'b00_10: map_code = 4'h3;
      4'b00_11: map_code = 4'hA;
      4'b01_00: map_code = 4'h4;
      4'b01_01: map_code = 4'h5;
      4'b01_10: map_code = 4'h6;
      4'b01_11: map_code = 4'hB;
      4'b10_00: map_code = 4'h7;
      4'b10_01: map_code = 4'h8;
      4'b10_10: map_code = 4'h9;
      4'b10_11: map_code = 4'hC;
      4'b11_00: map_code = 4'h0;
      4'b11_01: map_code = 4'hF;
      4'b11_10: map_code = 4'hE;
      default:  map_code = 4'hD;
    endcase
  end

  // Scan / debounce / held / release FSM with registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StScan;
      scan_cnt_q <= '0;
      deb_cnt_q  <= '0;
      col_idx_q  <= 2'd0;
      pat_q      <= 4'hF;
      col        <= 4'b1110;
      value      <= 32'h0;
      key_code   <= 4'h0;
      key_valid  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      unique case (state_q)
        StScan: begin
          if (scan_cnt_q == ScanLast) begin
            scan_cnt_q <= '0;
            if (row_s != 4'hF) begin
              // Column stays frozen; col_idx_q already names the hit column.
              pat_q     <= row_s;
              deb_cnt_q <= '0;
              state_q   <= StDebounce;
            end else begin
              col       <= {col[2:0], col[3]};
              col_idx_q <= col_idx_q + 2'd1;
            end
          end else begin
            scan_cnt_q <= scan_cnt_q + ScanW'(1);
          end
        end
        StDebounce: begin
          if (row_s != pat_q) begin
            state_q    <= StScan;
            scan_cnt_q <= '0;
            col        <= {col[2:0], col[3]};
            col_idx_q  <= col_idx_q + 2'd1;
          end else if (deb_cnt_q == DebLast) begin
            key_code  <= map_code;
            value     <= {value[27:0], map_code};
            key_valid <= 1'b1;
            state_q   <= StHeld;
          end else begin
            deb_cnt_q <= deb_cnt_q + DebW'(1);
          end
        end
        StHeld: begin
          // Extra keys pressed here are ignored; only full release matters.
          if (row_s == 4'hF) begin
            deb_cnt_q <= '0;
            state_q   <= StRelease;
          end
        end
        StRelease: begin
          if (row_s != 4'hF) begin
            state_q <= StHeld;
          end else if (deb_cnt_q == DebLast) begin
            state_q    <= StScan;
            scan_cnt_q <= '0;
            col        <= {col[2:0], col[3]};
            col_idx_q  <= col_idx_q + 2'd1;
          end else begin
            deb_cnt_q <= deb_cnt_q + DebW'(1);
          end
        end
        default: state_q <= StScan;
      endcase
    end
  end

endmodule
